// File: rtl/remap_pkg.sv
// Shared encodings and table entry types for the programmable piecewise-linear remapper.
package remap_pkg;

  localparam int SLOPE_SHIFT_W = 3;

  typedef enum logic [1:0] {
    SLOPE_ZERO    = 2'd0,
    SLOPE_ADD_SHL = 2'd1,
    SLOPE_SUB_SHR = 2'd2,
    SLOPE_ADD_SHR = 2'd3
  } slope_mode_e;

  typedef enum logic [1:0] {
    CFG_NODE   = 2'd0,
    CFG_INTCPT = 2'd1,
    CFG_SLOPE  = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_sel_e;

  typedef struct packed {
    slope_mode_e                mode;
    logic [SLOPE_SHIFT_W-1:0]   shift;
  } slope_t;

endpackage

// File: rtl/remap_piece_find.sv
// Piece search: parallel range compares against the node table, lowest matching index wins.
module remap_piece_find #(
  parameter int IN_W      = 16,
  parameter int PIECE_NUM = 42,
  parameter int IDX_W     = $clog2(PIECE_NUM+1)
) (
  input  logic [IN_W-1:0]                m_i,
  input  logic [PIECE_NUM:0][IN_W-1:0]   node_i,
  output logic                           hit_o,
  output logic [IDX_W-1:0]               idx_o
);

  logic [PIECE_NUM-1:0] match;

  for (genvar i = 0; i < PIECE_NUM; i++) begin : g_cmp
    assign match[i] = (node_i[i] < m_i) && (m_i <= node_i[i+1]);
  end

  // Walk downward so the lowest match is the final assignment.
  always_comb begin
    hit_o = |match;
    idx_o = '0;
    for (int i = PIECE_NUM-1; i >= 0; i--) begin
      if (match[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/remap_pipe.sv
// Three-stage remapper: S1 capture, S2 piece search, S3 slope/intercept arithmetic.
// Tables are only writable while the pipeline is empty, so samples never see a partial update.
module remap_pipe
  import remap_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int PIECE_NUM = 42,
  parameter int SHIFT_W   = SLOPE_SHIFT_W,
  parameter int IDX_W     = $clog2(PIECE_NUM+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W-2:0]   out_data,
  output logic              out_hit,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_sel,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [IN_W-1:0]   cfg_wdata
);

  logic [PIECE_NUM:0][IN_W-1:0]   node_q;
  logic [PIECE_NUM-1:0][IN_W-1:0] intcpt_q;
  slope_t [PIECE_NUM-1:0]         slope_q;

  logic [3:1]       vld_q;
  logic [IN_W-1:0]  m1_q, m2_q;
  logic [IDX_W-1:0] idx2_q, idx_d;
  logic             hit2_q, hit_d;
  logic [IN_W-2:0]  data3_q, data_d;
  logic             hit3_q;

  logic stall, accept, cfg_wr;

  assign stall     = vld_q[3] & ~out_ready;
  assign in_ready  = ~stall & ~cfg_we;
  assign accept    = in_valid & in_ready;
  assign cfg_ready = ~|vld_q;
  assign cfg_wr    = cfg_we & cfg_ready;

  assign out_valid = vld_q[3];
  assign out_data  = data3_q;
  assign out_hit   = hit3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q   <= '0;
      intcpt_q <= '0;
      slope_q  <= '0;
    end else if (cfg_wr) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_NODE:   if (cfg_addr <= IDX_W'(PIECE_NUM)) node_q[cfg_addr]  <= cfg_wdata;
        CFG_INTCPT: if (cfg_addr <  IDX_W'(PIECE_NUM)) intcpt_q[cfg_addr] <= cfg_wdata;
        CFG_SLOPE:  if (cfg_addr <  IDX_W'(PIECE_NUM))
                      slope_q[cfg_addr] <= slope_t'(cfg_wdata[SHIFT_W+1:0]);
        default: ;
      endcase
    end
  end

  remap_piece_find #(.IN_W(IN_W), .PIECE_NUM(PIECE_NUM), .IDX_W(IDX_W)) u_find (
    .m_i    (m1_q),
    .node_i (node_q),
    .hit_o  (hit_d),
    .idx_o  (idx_d)
  );

  // S3 arithmetic, all modulo 2^IN_W; a miss forces slope and intercept to zero.
  logic [IN_W-1:0] slope_term, intcpt, r;
  slope_t          se;

  always_comb begin
    se         = slope_q[idx2_q];
    intcpt     = intcpt_q[idx2_q];
    slope_term = '0;
    case (se.mode)
      SLOPE_ZERO:    slope_term = '0;
      SLOPE_ADD_SHL: slope_term = m2_q << se.shift;
      SLOPE_SUB_SHR: slope_term = -(m2_q >> se.shift);
      SLOPE_ADD_SHR: slope_term = m2_q >> se.shift;
      default:       slope_term = '0;
    endcase
    if (!hit2_q) begin
      slope_term = '0;
      intcpt     = '0;
    end
    r      = m2_q + slope_term + intcpt;
    data_d = r[IN_W-1:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      idx2_q  <= '0;
      hit2_q  <= 1'b0;
      data3_q <= '0;
      hit3_q  <= 1'b0;
    end else if (!stall) begin
      vld_q <= {vld_q[2:1], accept};
      if (accept) m1_q <= in_data;
      if (vld_q[1]) begin
        m2_q   <= m1_q;
        idx2_q <= idx_d;
        hit2_q <= hit_d;
      end
      if (vld_q[2]) begin
        data3_q <= data_d;
        hit3_q  <= hit2_q;
      end
    end
  end

endmodule

// File: tb/tb_remap_pipe.sv
// Directed bench with a scoreboard queue: stimulus pushes hand-computed results, a monitor pops on each output beat.
module tb_remap_pipe;

  localparam int IN_W  = 16;
  localparam int PN    = 42;
  localparam int IDX_W = 6;

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, out_hit;
  logic [IN_W-1:0]  in_data;
  logic [IN_W-2:0]  out_data;
  logic             cfg_we, cfg_ready;
  logic [1:0]       cfg_sel;
  logic [IDX_W-1:0] cfg_addr;
  logic [IN_W-1:0]  cfg_wdata;

  remap_pipe #(.IN_W(IN_W), .PIECE_NUM(PN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_hit(out_hit),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IN_W-2:0] d;
    logic            h;
    int              acc;
    bit              lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Entered and left at posedge+1; lat requests an exact 3-cycle latency check.
  task automatic send(input logic [IN_W-1:0] m, input logic [IN_W-2:0] d, input logic h, input bit lat);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = m;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) sb.push_back('{d, h, cyc, lat});
    else    chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [IDX_W-1:0] a, input logic [IN_W-1:0] wd);
    bit ok = 0;
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_wdata = wd;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("cfg_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  logic            held_v = 1'b0;
  logic [IN_W-1:0] held_d;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) held_v = 1'b0;
    else begin
      if (out_valid && held_v) chk("hold_stable", {out_hit, out_data}, held_d);
      if (out_valid && !out_ready) begin
        held_v = 1'b1;
        held_d = {out_hit, out_data};
      end else held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_hit", out_hit, e.h);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Nodes 0,100,200,300; piece0 shl2, piece1 +10, piece2 -(m>>3)+40
    cfg_write(2'd0, 6'd0, 16'd0);
    cfg_write(2'd0, 6'd1, 16'd100);
    cfg_write(2'd0, 6'd2, 16'd200);
    cfg_write(2'd0, 6'd3, 16'd300);
    cfg_write(2'd2, 6'd0, 16'd10);
    cfg_write(2'd2, 6'd1, 16'd0);
    cfg_write(2'd1, 6'd1, 16'd10);
    cfg_write(2'd2, 6'd2, 16'd19);
    cfg_write(2'd1, 6'd2, 16'd40);
    cfg_write(2'd1, 6'd50, 16'd999);   // out of range, dropped
    cfg_write(2'd3, 6'd0, 16'd999);    // reserved select, dropped

    send(16'd50,  15'd125, 1'b1, 1'b1);
    send(16'd150, 15'd80,  1'b1, 1'b1);
    send(16'd240, 15'd125, 1'b1, 1'b1);
    drain();

    send(16'd100, 15'd250, 1'b1, 1'b1);
    send(16'd101, 15'd55,  1'b1, 1'b1);
    send(16'd0,   15'd0,   1'b0, 1'b1);
    send(16'd301, 15'd150, 1'b0, 1'b1);
    drain();

    out_ready = 1'b0;
    fork
      begin
        send(16'd10, 15'd25,  1'b1, 1'b0);
        send(16'd20, 15'd50,  1'b1, 1'b0);
        send(16'd30, 15'd75,  1'b1, 1'b0);
        send(16'd40, 15'd100, 1'b1, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    send(16'd150, 15'd80,  1'b1, 1'b1);
    send(16'd240, 15'd125, 1'b1, 1'b1);
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 6'd1; cfg_wdata = 16'd30;
    @(negedge clk);
    chk("cfg_busy_ready", cfg_ready, 0);
    chk("cfg_blocks_in", in_ready, 0);
    @(posedge clk); #1;
    cfg_write(2'd1, 6'd1, 16'd30);
    send(16'd150, 15'd90, 1'b1, 1'b1);
    drain();

    cfg_write(2'd1, 6'd0, 16'hFFF0);
    send(16'd50, 15'h75, 1'b1, 1'b1);
    drain();

    send(16'd50,  15'h75,  1'b1, 1'b0);
    send(16'd150, 15'd90,  1'b1, 1'b0);
    send(16'd240, 15'd125, 1'b1, 1'b0);
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'd50,  15'd25, 1'b0, 1'b1);
    send(16'd150, 15'd75, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/remap_pipe.md
Name: remap_pipe

Overview:
- Programmable, pipelined piecewise-linear remapper: maps input code m to output code (m + slope_term(m) + intercept) >> 1.
- Breakpoint, intercept and slope tables are runtime-writable through a config port instead of fixed constants.
- Streams one sample per cycle with valid/ready backpressure.
- Sits between the measurement front end and downstream consumers of the remapped code.

Parameters:
- IN_W, 16, input code width; output width is IN_W-1.
- PIECE_NUM, 42, number of pieces; node table holds PIECE_NUM+1 entries.
- SHIFT_W, 3, width of the per-piece slope shift amount.
- IDX_W, $clog2(PIECE_NUM+1), derived; width of piece index and cfg address.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid & in_ready.
- in_data  in  IN_W  input code m (unsigned).
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_data  out  IN_W-1  remapped code.
- out_hit  out  1  1 = m fell in a programmed piece; 0 = passthrough.
- cfg_we  in  1  table write strobe.
- cfg_ready  out  1  1 when a config write is accepted (pipeline empty).
- cfg_sel  in  2  0 = node, 1 = intercept, 2 = slope, 3 = reserved (write ignored).
- cfg_addr  in  IDX_W  table index.
- cfg_wdata  in  IN_W  write data; slope uses bits [SHIFT_W+1:0] = {mode[1:0], shift}.

Behaviour:
- Single clock, asynchronous active-low reset.
- Reset: all stage valids 0, out_valid 0, out_data 0, out_hit 0; all table entries 0. With all nodes 0, no piece matches.
- Pipeline:
  - S1 registers in_data.
  - S2 runs piece search and registers piece index + hit.
  - S3 looks up intercept/slope, computes, and registers out_data/out_hit.
- Latency: 3 cycles from accept to out_valid, with no stall. Throughput is 1 sample/cycle.
- Piece search: piece i matches when node[i] < m <= node[i+1], i in 0..PIECE_NUM-1. On multiple matches (mis-programmed overlap), the lowest index wins.
- Slope term by mode:
  - 0: 0.
  - 1: +(m << shift).
  - 2: -(m >> shift).
  - 3: +(m >> shift).
- Arithmetic: r = m + slope_term + intercept, computed modulo 2^IN_W (wrap, no saturation); out_data = r[IN_W-1:1]. Shifted-out bits of m << shift are discarded.
- Miss (no piece matches, including m <= node[0] or m > node[PIECE_NUM]): slope_term = 0, intercept = 0, out_hit = 0, so out_data = m >> 1.
- Backpressure: stall = out_valid & ~out_ready. On stall, all stages hold; in_ready = ~stall & ~cfg_we. Bubbles are not collapsed. out_data/out_hit stay stable while out_valid & ~out_ready.
- Config:
  - cfg_ready = ~(S1, S2 and S3 valid all 0 negated), i.e. 1 only when the pipeline is empty.
  - Write occurs on cfg_we & cfg_ready and is visible to a sample accepted on the next cycle.
  - cfg_we asserted blocks new input acceptance that cycle, so config and data never race.
  - cfg_we with cfg_ready = 0: write dropped; master must hold cfg_we until cfg_ready.
  - Out-of-range addresses are ignored: intercept/slope >= PIECE_NUM, node > PIECE_NUM.
- Reset mid-stream: in-flight samples are discarded and tables return to 0; no output until new input.

Decomposition:
- Package remap_pkg holds:
  - slope mode encodings (SLOPE_ZERO, SLOPE_ADD_SHL, SLOPE_SUB_SHR, SLOPE_ADD_SHR);
  - cfg_sel codes (CFG_NODE, CFG_INTCPT, CFG_SLOPE);
  - the slope entry packed type.
- Sub-module remap_piece_find: combinational comparators plus priority encoder, producing {hit, index} from m and the node table.

Test Plan (IN_W=16; nodes 0,100,200,300; piece0 mode1 shift2 intcpt 0; piece1 mode0 intcpt 10; piece2 mode2 shift3 intcpt 40):
- Stream m = 50, 150, 240 back-to-back, out_ready = 1 -> out_data 125, 80, 125, all hit = 1, each 3 cycles after accept, on consecutive cycles.
- Boundaries: m = 100 -> 250 (piece0); m = 101 -> 55 (piece1); m = 0 -> 0, hit 0; m = 301 -> 150, hit 0.
- Hold out_ready = 0 for 5 cycles with 4 samples sent -> in_ready drops, out_data stable, no loss or duplication; order is preserved after release.
- Assert cfg_we while samples are in flight -> cfg_ready = 0 until drained. Rewrite piece1 intcpt to 30 -> m = 150 then gives 90.
- Wrap: piece0 intcpt 0xFFF0, m = 50 -> r = 0x00EA, out 0x75.
- Deassert rst_n mid-stream with 3 samples in flight -> out_valid 0 immediately; tables zeroed, so m = 50 then gives 25 with hit 0.
